pipe_addsub_sat: RTL

- Parametrised, pipelined signed adder/subtractor for the pipelined MIPS datapath. Replaces the single-cycle combinational adder where long word lengths limit timing.
- The WL-bit operation is split into SEG carry-chained segments, one segment per pipeline stage. Each stage registers its carry and the not-yet-used operand bits.
- Adds subtract mode, overflow detection, optional saturation, stall and flush. Accepts one operation per cycle.

---
 rtl/pipe_addsub_sat.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_addsub_sat.sv
// pipe_addsub_sat
//   Pipelined signed adder/subtractor with signed-overflow detection and
//   optional saturation. The WL-bit operation is cut into SEG carry-chained
//   segments of SW = WL/SEG bits. Segment i is added in pipeline stage i, so
//   the longest combinational path is a single SW-bit adder (plus the
//   saturation mux in the last stage). One operation is accepted per cycle.
//   An operation captured at edge k is presented with out_valid=1 after
//   edge k+SEG-1.
//
//   WL must be a multiple of SEG and WL >= 2.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (clears control and data)
//   in_valid   an operation is present on a/b/sub/sat
//   a, b       signed operands, WL bits
//   sub        1: a - b, 0: a + b
//   sat        1: clamp to the signed range on overflow, 0: wrap
//   stall      hold every pipeline register, in_valid is ignored
//   flush      clear every valid bit at the next edge (wins over stall)
//   out_valid  out/ovf hold a completed result
//   out        registered signed result
//   ovf        registered signed-overflow flag for out
module pipe_addsub_sat #(
    parameter int WL  = 32,
    parameter int SEG = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [WL-1:0] a,
    input  logic [WL-1:0] b,
    input  logic          sub,
    input  logic          sat,
    input  logic          stall,
    input  logic          flush,
    output logic          out_valid,
    output logic [WL-1:0] out,
    output logic          ovf
);

    localparam int SW  = WL / SEG;
    localparam int SW1 = SW + 1;

    // Subtraction is a + ~b + 1: invert b here and feed sub in as carry-in.
    logic [WL-1:0] w_bx;
    assign w_bx = sub ? ~b : b;

    // Clamp value takes the sign of a: when both operands share a sign and
    // the result flips it, the true result lies beyond that operand's side.
    function automatic logic [WL-1:0] f_saturate(
        input logic [WL-1:0] raw,
        input logic          ovf_i,
        input logic          sat_i,
        input logic          a_msb
    );
        logic [WL-1:0] lim;
        lim = {a_msb, {(WL-1){~a_msb}}};
        if (sat_i && ovf_i)
            return lim;
        else
            return raw;
    endfunction

    // ---------------- stages 0 .. SEG-2 (registered segments) ----------------
    // Each stage adds its low SW operand bits, appends the sum above the lower
    // sums already produced and forwards only the still-unused operand bits.
    genvar gi;
    generate
        for (gi = 0; gi < SEG - 1; gi++) begin : g_stg
            localparam int RW = WL - gi * SW;   // operand bits still unused on entry

            logic [RW-1:0]         w_a_in;
            logic [RW-1:0]         w_bx_in;
            logic                  w_c_in;
            logic                  w_sat_in;
            logic                  w_vld_in;
            logic [SW:0]           w_seg;
            logic [(gi+1)*SW-1:0]  w_sum_nxt;

            logic [(gi+1)*SW-1:0]  r_sum;
            logic [RW-SW-1:0]      r_a_hi;
            logic [RW-SW-1:0]      r_bx_hi;
            logic                  r_c;
            logic                  r_sat;
            logic                  r_vld;

            assign w_seg = {1'b0, w_a_in[SW-1:0]} + {1'b0, w_bx_in[SW-1:0]} + SW1'(w_c_in);

            if (gi == 0) begin : g_src
                assign w_a_in    = a;
                assign w_bx_in   = w_bx;
                assign w_c_in    = sub;
                assign w_sat_in  = sat;
                assign w_vld_in  = in_valid;
                assign w_sum_nxt = w_seg[SW-1:0];
            end else begin : g_src
                assign w_a_in    = g_stg[gi-1].r_a_hi;
                assign w_bx_in   = g_stg[gi-1].r_bx_hi;
                assign w_c_in    = g_stg[gi-1].r_c;
                assign w_sat_in  = g_stg[gi-1].r_sat;
                assign w_vld_in  = g_stg[gi-1].r_vld;
                assign w_sum_nxt = {w_seg[SW-1:0], g_stg[gi-1].r_sum};
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sum   <= '0;
                    r_a_hi  <= '0;
                    r_bx_hi <= '0;
                    r_c     <= 1'b0;
                    r_sat   <= 1'b0;
                    r_vld   <= 1'b0;
                end else begin
                    if (!stall) begin
                        r_sum   <= w_sum_nxt;
                        r_a_hi  <= w_a_in[RW-1:SW];
                        r_bx_hi <= w_bx_in[RW-1:SW];
                        r_c     <= w_seg[SW];
                        r_sat   <= w_sat_in;
                    end
                    if (flush)
                        r_vld <= 1'b0;
                    else if (!stall)
                        r_vld <= w_vld_in;
                end
            end
        end
    endgenerate

    // ---------------- final stage: top segment, overflow, saturation --------
    logic [SW-1:0] w_last_a;
    logic [SW-1:0] w_last_bx;
    logic          w_last_c;
    logic          w_last_sat;
    logic          w_last_vld;
    logic [SW-1:0] w_last_sum;
    logic [WL-1:0] w_raw;
    logic          w_a_msb;
    logic          w_bx_msb;
    logic          w_ovf;
    logic [WL-1:0] w_out;

    generate
        if (SEG == 1) begin : g_last_src
            assign w_last_a   = a;
            assign w_last_bx  = w_bx;
            assign w_last_c   = sub;
            assign w_last_sat = sat;
            assign w_last_vld = in_valid;
            assign w_raw      = w_last_sum;
        end else begin : g_last_src
            assign w_last_a   = g_stg[SEG-2].r_a_hi;
            assign w_last_bx  = g_stg[SEG-2].r_bx_hi;
            assign w_last_c   = g_stg[SEG-2].r_c;
            assign w_last_sat = g_stg[SEG-2].r_sat;
            assign w_last_vld = g_stg[SEG-2].r_vld;
            assign w_raw      = {w_last_sum, g_stg[SEG-2].r_sum};
        end
    endgenerate

    // Carry out of the MSB is dropped: arithmetic wraps modulo 2^WL.
    assign w_last_sum = w_last_a + w_last_bx + SW'(w_last_c);

    // The operand MSBs are the top bits of the last segment still in flight.
    assign w_a_msb  = w_last_a[SW-1];
    assign w_bx_msb = w_last_bx[SW-1];
    assign w_ovf    = (w_a_msb == w_bx_msb) && (w_raw[WL-1] != w_a_msb);
    assign w_out    = f_saturate(w_raw, w_ovf, w_last_sat, w_a_msb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (!stall) begin
                out <= w_out;
                ovf <= w_ovf;
            end
            if (flush)
                out_valid <= 1'b0;
            else if (!stall)
                out_valid <= w_last_vld;
        end
    end

endmodule
